// File: rtl/led_driver.sv
// rtl/led_driver.sv - memory-mapped 24-bit LED driver with per-LED hardware blink
module led_driver #(
    parameter int PRESCALE = 23000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ledctrl,
    input  logic        iowrite,
    input  logic        ioread,
    input  logic [3:0]  ledaddr,
    input  logic [15:0] ledwdata,
    output logic [15:0] ledrdata,
    output logic [23:0] led_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [23:0] led;
    logic [23:0] bmask;
    logic [15:0] period;
    logic [PW-1:0] pre_cnt;
    logic [15:0] per_cnt;
    logic        phase;
    logic        we;
    logic        tick;
    logic        period_we;

    assign we        = ledctrl & iowrite;
    assign period_we = we && (ledaddr == 4'h8);
    assign tick      = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led   <= '0;
            bmask <= '0;
        end else if (we) begin
            case (ledaddr)
                4'h0: led[15:0]    <= ledwdata;
                4'h2: led[23:16]   <= ledwdata[7:0];
                4'h4: bmask[15:0]  <= ledwdata;
                4'h6: bmask[23:16] <= ledwdata[7:0];
                default: ;
            endcase
        end
    end

    // A period write restarts the whole blink timebase and beats any coincident tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period  <= '0;
            pre_cnt <= '0;
            per_cnt <= '0;
            phase   <= 1'b1;
        end else if (period_we) begin
            period  <= ledwdata;
            pre_cnt <= '0;
            per_cnt <= '0;
            phase   <= 1'b1;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (period == 16'd0) begin
                per_cnt <= '0;
                phase   <= 1'b1;
            end else if (tick) begin
                if (per_cnt == period - 16'd1) begin
                    per_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    per_cnt <= per_cnt + 16'd1;
                end
            end
        end
    end

    assign led_out = led & ~(bmask & {24{~phase}});

    always_comb begin
        ledrdata = 16'h0;
        if (ledctrl && ioread) begin
            case (ledaddr)
                4'h0: ledrdata = led[15:0];
                4'h2: ledrdata = {8'h0, led[23:16]};
                4'h4: ledrdata = bmask[15:0];
                4'h6: ledrdata = {8'h0, bmask[23:16]};
                4'h8: ledrdata = period;
                default: ledrdata = 16'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// tb/tb_led_driver.sv - scoreboard bench for led_driver with PRESCALE=4
module tb_led_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ledctrl = 1'b0;
    logic        iowrite = 1'b0;
    logic        ioread = 1'b0;
    logic [3:0]  ledaddr = 4'h0;
    logic [15:0] ledwdata = 16'h0;
    logic [15:0] ledrdata;
    logic [23:0] led_out;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] e;

    always #5 clock = ~clock;

    led_driver #(.PRESCALE(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .ledctrl  (ledctrl),
        .iowrite  (iowrite),
        .ioread   (ioread),
        .ledaddr  (ledaddr),
        .ledwdata (ledwdata),
        .ledrdata (ledrdata),
        .led_out  (led_out)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        ledctrl = 1'b1; iowrite = 1'b1; ioread = 1'b0; ledaddr = a; ledwdata = d;
        step();
        ledctrl = 1'b0; iowrite = 1'b0; ledwdata = 16'h0;
    endtask

    task automatic test_reset();
        #12;
        exp_q.push_back(24'h0);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL reset_led_out got %h exp %h", led_out, e);
        end
        for (int a = 0; a <= 8; a += 2) begin
            ledctrl = 1'b1; ioread = 1'b1; ledaddr = 4'(a); #1;
            exp_q.push_back(24'h0);
            e = exp_q.pop_front();
            checks++;
            if ({8'h0, ledrdata} !== e) begin
                errors++;
                $display("FAIL reset_read_%0h got %h exp %h", a, ledrdata, e[15:0]);
            end
        end
        ledctrl = 1'b0; ioread = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        // Read and write together: read shows old value before the edge, new after.
        ledctrl = 1'b1; iowrite = 1'b1; ioread = 1'b1; ledaddr = 4'h0; ledwdata = 16'hA5A5; #1;
        exp_q.push_back(24'h0);
        e = exp_q.pop_front();
        checks++;
        if ({8'h0, ledrdata} !== e) begin
            errors++;
            $display("FAIL rw_pre_edge got %h exp %h", ledrdata, e[15:0]);
        end
        step();
        iowrite = 1'b0;
        exp_q.push_back(24'h00A5A5);
        e = exp_q.pop_front();
        checks++;
        if ({8'h0, ledrdata} !== e) begin
            errors++;
            $display("FAIL rw_post_edge got %h exp %h", ledrdata, e[15:0]);
        end
        ioread = 1'b0; ledctrl = 1'b0;
        wr(4'h2, 16'hFF3C);
        exp_q.push_back(24'h3CA5A5);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL led_out_after_write got %h exp %h", led_out, e);
        end
        ledctrl = 1'b1; ioread = 1'b1; ledaddr = 4'h2; #1;
        exp_q.push_back(24'h00003C);
        e = exp_q.pop_front();
        checks++;
        if ({8'h0, ledrdata} !== e) begin
            errors++;
            $display("FAIL read_0x2 got %h exp %h", ledrdata, e[15:0]);
        end
        ledaddr = 4'hA; #1;
        exp_q.push_back(24'h0);
        e = exp_q.pop_front();
        checks++;
        if ({8'h0, ledrdata} !== e) begin
            errors++;
            $display("FAIL read_0xA got %h exp %h", ledrdata, e[15:0]);
        end
        ledctrl = 1'b0; ioread = 1'b0;
    endtask

    task automatic test_no_select();
        ledctrl = 1'b0; iowrite = 1'b1; ioread = 1'b1; ledaddr = 4'h0; ledwdata = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_q.push_back(24'h3CA5A5);
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e) begin
                errors++;
                $display("FAIL nosel_led_out cyc %0d got %h exp %h", k, led_out, e);
            end
            exp_q.push_back(24'h0);
            e = exp_q.pop_front();
            checks++;
            if ({8'h0, ledrdata} !== e) begin
                errors++;
                $display("FAIL nosel_rdata cyc %0d got %h exp %h", k, ledrdata, e[15:0]);
            end
        end
        iowrite = 1'b0; ioread = 1'b0; ledwdata = 16'h0;
    endtask

    task automatic test_blink();
        wr(4'h0, 16'h00FF);
        wr(4'h2, 16'h0000);
        wr(4'h4, 16'h000F);
        wr(4'h6, 16'h0000);
        wr(4'h8, 16'h0002);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) step();
            exp_q.push_back(((k / 8) % 2 == 0) ? 24'h0000FF : 24'h0000F0);
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e) begin
                errors++;
                $display("FAIL blink cyc %0d got %h exp %h", k, led_out, e);
            end
        end
    endtask

    task automatic test_disable_mid_dark();
        repeat (11) step();
        exp_q.push_back(24'h0000F0);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL dark_before_disable got %h exp %h", led_out, e);
        end
        wr(4'h8, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            exp_q.push_back(24'h0000FF);
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e) begin
                errors++;
                $display("FAIL disabled cyc %0d got %h exp %h", k, led_out, e);
            end
        end
    endtask

    task automatic test_write_on_toggle();
        wr(4'h8, 16'h0002);
        repeat (7) step();
        exp_q.push_back(24'h0000FF);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL pre_toggle got %h exp %h", led_out, e);
        end
        // This write lands on the edge where phase would have gone dark.
        wr(4'h8, 16'h0003);
        for (int k = 0; k < 26; k++) begin
            if (k > 0) step();
            exp_q.push_back(((k / 12) % 2 == 0) ? 24'h0000FF : 24'h0000F0);
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e) begin
                errors++;
                $display("FAIL restart cyc %0d got %h exp %h", k, led_out, e);
            end
        end
    endtask

    task automatic test_async_reset();
        wr(4'h8, 16'h0001);
        step();
        exp_q.push_back(24'h0000FF);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL before_async_reset got %h exp %h", led_out, e);
        end
        #3;
        reset = 1'b1;
        #1;
        exp_q.push_back(24'h0);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL async_reset_led_out got %h exp %h", led_out, e);
        end
        for (int a = 0; a <= 8; a += 2) begin
            ledctrl = 1'b1; ioread = 1'b1; ledaddr = 4'(a); #0.5;
            exp_q.push_back(24'h0);
            e = exp_q.pop_front();
            checks++;
            if ({8'h0, ledrdata} !== e) begin
                errors++;
                $display("FAIL async_reset_read_%0h got %h exp %h", a, ledrdata, e[15:0]);
            end
        end
        ledctrl = 1'b0; ioread = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        exp_q.push_back(24'h0);
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL after_reset_release got %h exp %h", led_out, e);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_no_select();
        test_blink();
        test_disable_mid_dark();
        test_write_on_toggle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
